ssd_bcd_scan_driver: RTL
========================

// Module: ssd_bcd_scan_driver
// PURPOSE
//  Parametrised SSD driver: captures an unsigned binary value (level/score) on a load strobe, converts
//  it to BCD with a sequential shift-add-3 (double-dabble) FSM, and time-multiplexes NUM_DIGITS digits
//  onto the board's 8 active-low anodes and shared active-low cathodes. Replaces ad hoc SSD scan logic in tops.
// PARAMETERS
//  NUM_DIGITS  4   digits driven, 1..8; An[NUM_DIGITS-1:0] used, rest held high
//  VAL_W       9   width of value input, 1..27
//  SCAN_DIV_W  18  prescaler width; each digit lit 2^SCAN_DIV_W Clk cycles (2.62 ms at 100 MHz)
// PORTS
//  Clk       in   1          system clock (board_clk)
//  Reset     in   1          synchronous, active-high reset
//  value     in   VAL_W      unsigned binary value to display
//  load      in   1          1-cycle strobe: capture value and start conversion
//  busy      out  1          conversion in progress
//  done      out  1          1-cycle pulse when display registers update
//  ovf       out  1          last converted value exceeded 10^NUM_DIGITS-1
//  An        out  8          anodes, active low, bit i = digit i (digit 0 = ones, rightmost)
//  Cath      out  8          {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active low
// BEHAVIOUR
//  Reset: FSM->IDLE; busy=0, done=0, ovf=0; display digits all 0; prescaler=0, digit index=0;
//   An=8'hFF and Cath=8'hFF during the reset cycle; first digit lit on cycle after Reset deasserts.
//  FSM IDLE -> CONV on load; CONV -> FIN after VAL_W shift cycles; FIN -> IDLE unconditionally.
//   IDLE: load=1 captures value into shift reg, clears BCD reg (4*NUM_DIGITS + 4 bits incl. guard digit).
//   CONV: per cycle, add 3 to every BCD nibble >=5, then shift {bcd,shift} left 1; busy=1.
//   FIN : copy low NUM_DIGITS nibbles to display regs; ovf = (guard nibble !=0) | (value > 10^NUM_DIGITS-1);
//         done=1 this cycle only; busy=0.
//  Latency: load sampled in cycle N -> busy 1 in N+1..N+VAL_W, done in N+VAL_W+1, new digits visible from N+VAL_W+2.
//  load while busy or in FIN: ignored (no queueing); display holds previous result throughout CONV.
//  ovf=1: all NUM_DIGITS digits show dash (Cath=8'b11111101) until next successful conversion.
//  Scan: prescaler counts 0..2^SCAN_DIV_W-1; on wrap digit index advances, wrapping NUM_DIGITS-1 -> 0.
//   An = ~(8'b1 << idx); anodes >= NUM_DIGITS always 1. NUM_DIGITS=1: idx fixed 0, An=8'hFE.
//  Outputs An, Cath registered (one-cycle after idx/display regs); no glitch between digits.
//  Segment codes (Cath): 0=03 1=9F 2=25 3=0D 4=99 5=49 6=41 7=1F 8=01 9=09 (hex), Dp always 1.
//  Reset mid-conversion: abort, display regs cleared to 0, no done pulse.
// CONFIGURATION
//  SSD_LZ_BLANK_EN defined: leading-zero blanking; digit i>0 shows Cath=8'hFF (anode still scanned) when it
//   and all higher digits are 0; digit 0 never blanked; dashes (ovf) never blanked.
//  Not defined: every digit shows its value, leading zeros included.
// TESTING (bench uses SCAN_DIV_W=2, NUM_DIGITS=4, VAL_W=9)
//  Reset held 3 cycles -> busy=0 done=0 ovf=0, An=FF Cath=FF; after release digits show 0,0,0,0 (Cath=03).
//  value=9'd255, load pulse at N -> busy N+1..N+9, done at N+10; digits d0..d3 = 5,5,2,0 (Cath 49,49,25,03/FF if LZ).
//  load with value=9'd17 during busy of 255 conversion -> ignored; result still 255, single done pulse.
//  NUM_DIGITS=2, value=9'd100 -> ovf=1, both digits Cath=FD; then load 9'd42 -> ovf=0, digits 2,4.
//  Scan check: An sequence FE,FD,FB,F7,FE... each held 4 cycles; An[7:4] never 0.
//  Reset asserted at busy cycle 4 -> busy=0, no done, display 0; next load 9'd9 -> digit0 Cath=09.

Source files
------------

// File: rtl/ssd_bcd_scan_driver.sv
// Seven-segment driver: captures a binary value, converts it to BCD by sequential double-dabble and
// scans NUM_DIGITS digits onto active-low anodes/cathodes. Optional macro SSD_LZ_BLANK_EN: leading-zero blanking.
module ssd_bcd_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 9,
  parameter int SCAN_DIV_W = 18
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [VAL_W-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [7:0]       An,
  output logic [7:0]       Cath
);

  localparam int BCD_W  = 4*NUM_DIGITS + 4;
  localparam int DISP_W = 4*NUM_DIGITS;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int k = 0; k < n; k++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

  localparam logic [31:0] MAX_VAL = pow10(NUM_DIGITS) - 32'd1;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'h03;
      4'd1:    seg_code = 8'h9F;
      4'd2:    seg_code = 8'h25;
      4'd3:    seg_code = 8'h0D;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h49;
      4'd6:    seg_code = 8'h41;
      4'd7:    seg_code = 8'h1F;
      4'd8:    seg_code = 8'h01;
      4'd9:    seg_code = 8'h09;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4:0]          r_cnt;
  logic [VAL_W-1:0]    r_shift;
  logic [VAL_W-1:0]    r_val;
  logic [BCD_W-1:0]    r_bcd;
  logic [BCD_W-1:0]    w_bcd_adj;
  logic [DISP_W-1:0]   r_disp;
  logic                r_ovf;
  logic [31:0]         w_val_ext;
  logic                w_ovf_nxt;
  logic [SCAN_DIV_W-1:0] r_pre;
  logic [2:0]          r_idx;
  logic [3:0]          w_digit;
  logic [7:0]          w_an_nxt;
  logic [7:0]          w_cath_nxt;
  logic [7:0]          r_an;
  logic [7:0]          r_cath;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        busy = 1'b1;
        if (r_cnt == 5'(VAL_W - 1)) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Add-3 correction on every nibble (guard included) before each shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int n = 0; n < NUM_DIGITS + 1; n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) begin
        w_bcd_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_shift <= '0;
      r_val   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift <= value;
            r_val   <= value;
            r_bcd   <= '0;
            r_cnt   <= '0;
          end
        end
        S_CONV: begin
          r_bcd   <= {w_bcd_adj[BCD_W-2:0], r_shift[VAL_W-1]};
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // The guard nibble alone misses values beyond 10^(NUM_DIGITS+1), hence the direct compare as well.
  assign w_val_ext = 32'(r_val);
  assign w_ovf_nxt = (r_bcd[BCD_W-1 -: 4] != 4'd0) || (w_val_ext > MAX_VAL);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_disp <= '0;
      r_ovf  <= 1'b0;
    end else if (r_state == S_FIN) begin
      r_disp <= r_bcd[DISP_W-1:0];
      r_ovf  <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      r_pre <= r_pre + SCAN_DIV_W'(1);
      if (&r_pre) begin
        r_idx <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
      end
    end
  end

  always_comb begin
    w_digit = 4'd0;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (r_idx == 3'(n)) begin
        w_digit = r_disp[4*n +: 4];
      end
    end
  end

`ifdef SSD_LZ_BLANK_EN
  logic w_blank;

  // Blank digit idx when it and every digit above it are zero; the ones digit always shows.
  always_comb begin
    w_blank = (r_idx != 3'd0);
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if ((3'(n) >= r_idx) && (r_disp[4*n +: 4] != 4'd0)) begin
        w_blank = 1'b0;
      end
    end
  end
`endif

  always_comb begin
    w_an_nxt = ~(8'h01 << r_idx);
    if (r_ovf) begin
      w_cath_nxt = 8'hFD;
`ifdef SSD_LZ_BLANK_EN
    end else if (w_blank) begin
      w_cath_nxt = 8'hFF;
`endif
    end else begin
      w_cath_nxt = seg_code(w_digit);
    end
  end

  // Anode and cathode change on the same edge, so no digit ever shows its neighbour's pattern.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_an   <= 8'hFF;
      r_cath <= 8'hFF;
    end else begin
      r_an   <= w_an_nxt;
      r_cath <= w_cath_nxt;
    end
  end

  assign An   = r_an;
  assign Cath = r_cath;

endmodule
